fetch_prefetch_queue: RTL and testbench

//   Next-generation instruction fetch unit: a pipelined prefetcher.

---
 rtl/fetch_prefetch_queue.sv | 142 ++++++++++++++
 tb/tb_fetch_prefetch_queue.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_queue.sv
// Pipelined instruction prefetcher: keeps in-order bus reads in flight,
// buffers little-endian words in a small queue, flushes on redirect.
module fetch_prefetch_queue #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        request_enable,
  output logic        mode,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  input  logic        response_enable,
  input  logic [31:0] data
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic MEMREQ_READ = 1'b0;
  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTSTANDING);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  function automatic logic [31:0] to_le32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   pc_q    [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] stale_q, stale_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic          req_en_q;
  logic [31:0]   addr_q;

  logic          resp_ok;
  logic          resp_drop;
  logic          push;
  logic          pop;
  logic          issue;
  logic [CW:0]   reserved;
  logic [31:0]   redir_pc;

  assign redir_pc  = redirect_pc & ~32'h3;
  assign resp_ok   = response_enable && (inflight_q != '0);
  assign resp_drop = resp_ok && (stale_q != '0);
  assign push      = resp_ok && !resp_drop && !redirect;
  assign pop       = (count_q != '0) && out_ready && !redirect;
  // Queue slots already spoken for: occupied plus live in-flight reads.
  assign reserved  = {1'b0, count_q} + {1'b0, inflight_q - stale_q};
  assign issue     = !redirect && (inflight_q < MAX_C) &&
                     (reserved < DEPTH_C);

  // Next-state for pointers, counters and fetch/response addresses.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    stale_d    = stale_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    if (redirect) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      inflight_d = inflight_q - CW'(resp_ok);
      stale_d    = inflight_q - CW'(resp_ok);
      fetch_pc_d = redir_pc;
      resp_pc_d  = redir_pc;
    end else begin
      inflight_d = inflight_q + CW'(issue) - CW'(resp_ok);
      stale_d    = stale_q - CW'(resp_drop);
      if (issue) fetch_pc_d = fetch_pc_q + 32'd4;
      if (push) begin
        tail_d    = tail_q + AW'(1);
        resp_pc_d = resp_pc_q + 32'd4;
      end
      if (pop) head_d = head_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Control state and the registered bus request.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      stale_q    <= '0;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      req_en_q   <= 1'b0;
      addr_q     <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      stale_q    <= stale_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      req_en_q   <= issue;
      if (issue) addr_q <= fetch_pc_q;
    end
  end

  // Queue storage: a returned word lands at the tail with its address.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else if (push) begin
      instr_q[tail_q] <= to_le32(data);
      pc_q[tail_q]    <= resp_pc_q;
    end
  end

  assign out_valid      = (count_q != '0);
  assign out_instr      = out_valid ? instr_q[head_q] : '0;
  assign out_pc         = out_valid ? pc_q[head_q] : '0;
  assign request_enable = req_en_q;
  assign mode           = MEMREQ_READ;
  assign addr           = addr_q;
  assign wdata          = '0;
  assign wstrb          = '0;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: a bus model answering reads in order
// and a queue-level reference of what decode should see.
module tb_fetch_prefetch_queue;

  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  logic        clk;
  logic        rstn;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        request_enable;
  logic        mode;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        response_enable;
  logic [31:0] data;

  fetch_prefetch_queue #(
    .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(32'h0)
  ) dut (
    .clk(clk), .rstn(rstn),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc),
    .request_enable(request_enable), .mode(mode),
    .addr(addr), .wdata(wdata), .wstrb(wstrb),
    .response_enable(response_enable), .data(data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        stale;
    int          seen;
  } pend_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  pend_t       pend[$];
  ent_t        mq[$];
  int          cyc;
  int          nreq;
  int          npop;
  logic [31:0] exp_fetch;
  logic        endian_mode;
  int          compared;
  int          mismatched;

  function automatic logic [31:0] word_of(input logic [31:0] pc);
    if (endian_mode) return 32'h00000013;
    return (pc * 32'h9E3779B1) ^ 32'h00000013;
  endfunction

  function automatic logic [31:0] bus_of(input logic [31:0] pc);
    logic [31:0] w;
    if (endian_mode) return 32'h13000000;
    w = word_of(pc);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic int live_pend();
    int n = 0;
    foreach (pend[i]) if (!pend[i].stale) n++;
    return n;
  endfunction

  // One clock of the bus + reference model; entered and left at negedge.
  task automatic bus_cycle(input bit redir, input logic [31:0] rpc,
                           input int rdy_mode, input int resp_mode,
                           input bit junk);
    bit   rdy;
    bit   resp;
    bit   popping;
    pend_t f;
    compared++;
    if (out_valid !== (mq.size() != 0)) begin
      mismatched++;
      $display("FAIL out_valid cyc=%0d got=%b want=%b",
               cyc, out_valid, mq.size() != 0);
    end
    if (mq.size() != 0) begin
      compared++;
      if (out_pc !== mq[0].pc || out_instr !== mq[0].instr) begin
        mismatched++;
        $display("FAIL head cyc=%0d got pc=%h ins=%h want pc=%h ins=%h",
                 cyc, out_pc, out_instr, mq[0].pc, mq[0].instr);
      end
    end
    if (request_enable === 1'b1) begin
      compared++;
      if (addr !== exp_fetch || mode !== 1'b0) begin
        mismatched++;
        $display("FAIL req_addr cyc=%0d got=%h want=%h mode=%b",
                 cyc, addr, exp_fetch, mode);
      end
      pend.push_back('{pc: exp_fetch, stale: 1'b0, seen: cyc});
      exp_fetch += 32'd4;
      nreq++;
    end
    compared++;
    if (pend.size() > MAXO || live_pend() + mq.size() > DEPTH) begin
      mismatched++;
      $display("FAIL bounds cyc=%0d got inflight=%0d live+q=%0d want<=%0d/%0d",
               cyc, pend.size(), live_pend() + mq.size(), MAXO, DEPTH);
    end
    rdy  = (rdy_mode == 1) || (rdy_mode == 2 && $urandom_range(1, 0) == 1);
    resp = (pend.size() != 0) && (pend[0].seen < cyc) &&
           ((resp_mode == 1) ||
            (resp_mode == 2 && $urandom_range(1, 0) == 1));
    redirect        = redir;
    redirect_pc     = rpc;
    out_ready       = rdy;
    response_enable = resp || (junk && pend.size() == 0);
    data            = resp ? bus_of(pend[0].pc) : 32'hDEADBEEF;
    popping = !redir && rdy && (mq.size() != 0);
    if (popping) begin
      void'(mq.pop_front());
      npop++;
    end
    if (resp) begin
      f = pend.pop_front();
      if (!redir && !f.stale)
        mq.push_back('{pc: f.pc, instr: word_of(f.pc)});
    end
    if (redir) begin
      mq.delete();
      foreach (pend[i]) pend[i].stale = 1'b1;
      exp_fetch = {rpc[31:2], 2'b00};
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    redirect        = 1'b0;
    response_enable = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn            = 1'b0;
    redirect        = 1'b0;
    redirect_pc     = '0;
    out_ready       = 1'b0;
    response_enable = 1'b0;
    data            = '0;
    pend.delete();
    mq.delete();
    exp_fetch   = 32'h0;
    endian_mode = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    compared++;
    if (request_enable !== 1'b0 || mode !== 1'b0 || addr !== 32'h0 ||
        out_valid !== 1'b0 || out_instr !== 32'h0 || out_pc !== 32'h0 ||
        wdata !== 32'h0 || wstrb !== 4'h0) begin
      mismatched++;
      $display("FAIL reset_vals got re=%b m=%b a=%h v=%b i=%h p=%h want zeros",
               request_enable, mode, addr, out_valid, out_instr, out_pc);
    end
    bus_cycle(1'b0, '0, 0, 0, 1'b1);
    compared++;
    if (request_enable !== 1'b1 || addr !== 32'h0) begin
      mismatched++;
      $display("FAIL first_req got re=%b addr=%h want 1/00000000",
               request_enable, addr);
    end
  endtask

  task automatic test_stream();
    int p0;
    do_reset();
    p0 = npop;
    for (int i = 0; i < 30; i++) bus_cycle(1'b0, '0, 1, 1, 1'b0);
    compared++;
    if (npop - p0 < 12) begin
      mismatched++;
      $display("FAIL stream_rate got=%0d want>=12", npop - p0);
    end
  endtask

  task automatic test_backpressure();
    int r0;
    do_reset();
    for (int i = 0; i < 14; i++) bus_cycle(1'b0, '0, 0, 1, 1'b0);
    compared++;
    if (nreq_since_reset() != 4 || mq.size() != 4 || out_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL fill got reqs=%0d q=%0d v=%b want 4/4/1",
               nreq_since_reset(), mq.size(), out_valid);
    end
    r0 = nreq;
    for (int i = 0; i < 4; i++) bus_cycle(1'b0, '0, 0, 1, 1'b0);
    compared++;
    if (nreq != r0) begin
      mismatched++;
      $display("FAIL full_hold got=%0d want=%0d", nreq, r0);
    end
    bus_cycle(1'b0, '0, 1, 1, 1'b0);
    for (int i = 0; i < 6; i++) bus_cycle(1'b0, '0, 0, 1, 1'b0);
    compared++;
    if (nreq != r0 + 1) begin
      mismatched++;
      $display("FAIL refill got=%0d want=%0d", nreq, r0 + 1);
    end
  endtask

  int nreq_base;
  function automatic int nreq_since_reset();
    return nreq - nreq_base;
  endfunction

  task automatic test_endian();
    do_reset();
    endian_mode = 1'b1;
    for (int i = 0; i < 8; i++) bus_cycle(1'b0, '0, 0, 1, 1'b0);
    compared++;
    if (out_valid !== 1'b1 || out_instr !== 32'h00000013) begin
      mismatched++;
      $display("FAIL endian got v=%b ins=%h want 1/00000013",
               out_valid, out_instr);
    end
    endian_mode = 1'b0;
  endtask

  task automatic test_redirect_flush();
    bit done;
    do_reset();
    for (int i = 0; i < 10 && pend.size() < 2; i++)
      bus_cycle(1'b0, '0, 1, 0, 1'b0);
    compared++;
    if (pend.size() != 2) begin
      mismatched++;
      $display("FAIL two_inflight got=%0d want=2", pend.size());
    end
    bus_cycle(1'b1, 32'h100, 1, 1, 1'b0);
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (out_valid === 1'b1) begin
        done = 1'b1;
        compared++;
        if (out_pc !== 32'h100) begin
          mismatched++;
          $display("FAIL flush_pc got=%h want=00000100", out_pc);
        end
      end else begin
        bus_cycle(1'b0, '0, 0, 1, 1'b0);
      end
    end
    if (!done) begin
      mismatched++;
      $display("FAIL flush_timeout got no out_valid want one");
    end
  endtask

  task automatic test_redirect_align();
    bit got_req;
    bit got_out;
    do_reset();
    for (int i = 0; i < 6; i++) bus_cycle(1'b0, '0, 2, 1, 1'b0);
    bus_cycle(1'b1, 32'h203, 0, 2, 1'b0);
    got_req = 1'b0;
    got_out = 1'b0;
    for (int i = 0; i < 30 && !got_out; i++) begin
      if (!got_req && request_enable === 1'b1) begin
        got_req = 1'b1;
        compared++;
        if (addr !== 32'h200) begin
          mismatched++;
          $display("FAIL align_addr got=%h want=00000200", addr);
        end
      end
      if (out_valid === 1'b1) begin
        got_out = 1'b1;
        compared++;
        if (out_pc !== 32'h200) begin
          mismatched++;
          $display("FAIL align_pc got=%h want=00000200", out_pc);
        end
      end else begin
        bus_cycle(1'b0, '0, 0, 1, 1'b0);
      end
    end
    if (!got_req || !got_out) begin
      mismatched++;
      $display("FAIL align_timeout got req=%b out=%b want 1/1",
               got_req, got_out);
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    for (int i = 0; i < 10 && pend.size() < 2; i++)
      bus_cycle(1'b0, '0, 1, 0, 1'b0);
    #1;
    rstn            = 1'b0;
    response_enable = 1'b0;
    #1;
    compared++;
    if (request_enable !== 1'b0 || addr !== 32'h0 || out_valid !== 1'b0 ||
        out_instr !== 32'h0 || out_pc !== 32'h0 || mode !== 1'b0) begin
      mismatched++;
      $display("FAIL async_rst got re=%b a=%h v=%b i=%h p=%h want zeros",
               request_enable, addr, out_valid, out_instr, out_pc);
    end
    pend.delete();
    mq.delete();
    exp_fetch = 32'h0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    bus_cycle(1'b0, '0, 1, 0, 1'b1);
    compared++;
    if (request_enable !== 1'b1 || addr !== 32'h0) begin
      mismatched++;
      $display("FAIL restart got re=%b addr=%h want 1/00000000",
               request_enable, addr);
    end
    for (int i = 0; i < 12; i++) bus_cycle(1'b0, '0, 1, 1, 1'b0);
  endtask

  task automatic test_random();
    int p0;
    bit redir;
    do_reset();
    p0 = npop;
    for (int i = 0; i < 400; i++) begin
      redir = ($urandom_range(15, 0) == 0);
      bus_cycle(redir, $urandom, 2, 2, 1'b0);
    end
    compared++;
    if (npop - p0 < 20) begin
      mismatched++;
      $display("FAIL random_progress got=%0d want>=20", npop - p0);
    end
  endtask

  initial begin
    compared    = 0;
    mismatched  = 0;
    cyc         = 0;
    nreq        = 0;
    npop        = 0;
    nreq_base   = 0;
    endian_mode = 1'b0;
    exp_fetch   = 32'h0;
    rstn        = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    out_ready   = 1'b0;
    response_enable = 1'b0;
    data        = '0;
    test_reset();
    test_stream();
    nreq_base = nreq;
    test_backpressure();
    test_endian();
    test_redirect_flush();
    test_redirect_align();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
